// File: rtl/priority_code_decoder_pkg.sv
// Shared constants, FSM state type and the code-to-one-hot helper for the priority codec.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   N, CW    vector width and code width (CW = log2(N))
//   state_t  decoder frame state {ACCUM, HOLD}
//   onehot() CW-bit code to N-bit one-hot; also used by the encoder-side checker
package priority_codec_pkg;

   // N must be a power of two and at least 2 so every CW-bit code maps to a real bit.
   localparam int N  = 8;
   localparam int CW = $clog2(N);

   typedef enum logic [0:0] {
      ACCUM = 1'b0,   // collecting beats of a frame
      HOLD  = 1'b1    // rebuilt vector presented, waiting for downstream
   } state_t;

   function automatic logic [N-1:0] onehot(input logic [CW-1:0] code);
      logic [N-1:0] v;
      v       = '0;
      v[code] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/priority_code_decoder_if.sv
// Bundles the code-beat input stream, the decode strobe and the rebuilt-vector output stream.
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready handshakes carried through unchanged.
//
// Signals:
//   in_valid/in_ready/in_code/in_last  framed stream of priority codes (upstream -> decoder)
//   dec_onehot/dec_valid               per-beat one-hot decode strobe (decoder -> observer)
//   out_x/out_err/out_valid/out_ready  rebuilt vector stream (decoder -> downstream)
// Modports: slave = decoder view, master = environment view.
interface priority_code_decoder_if;
   import priority_codec_pkg::*;

   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_code;
   logic          in_last;

   logic [N-1:0]  dec_onehot;
   logic          dec_valid;

   logic [N-1:0]  out_x;
   logic          out_err;
   logic          out_valid;
   logic          out_ready;

   modport slave (
      input  in_valid, in_code, in_last, out_ready,
      output in_ready, dec_onehot, dec_valid, out_x, out_err, out_valid
   );

   modport master (
      output in_valid, in_code, in_last, out_ready,
      input  in_ready, dec_onehot, dec_valid, out_x, out_err, out_valid
   );

endinterface

// File: rtl/priority_code_decoder_onehot_decoder.sv
// Combinational CW-to-N decoder: drives the single bit selected by the priority code.
// Latency: 0 cycles (pure combinational; the parent registers the result).
// Backpressure: none.
//
// Ports:
//   i_code    CW-bit priority code (index of a set bit)
//   o_onehot  N-bit one-hot strobe with bit i_code set
module onehot_decoder
   import priority_codec_pkg::*;
(
   input  logic [CW-1:0] i_code,
   output logic [N-1:0]  o_onehot
);

   always_comb begin
      o_onehot = onehot(i_code);
   end

endmodule

// File: rtl/priority_code_decoder.sv
// Rebuilds an N-bit vector from a framed stream of descending priority codes and flags order errors.
// Latency: dec_onehot 1 cycle after each accept; out_x/out_err 1 cycle after the last beat.
// Backpressure: in_ready drops while the rebuilt vector is held; resumes the cycle after out handshake.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; discards any partial frame
//   bus  priority_code_decoder_if.slave (code input stream, decode strobe, vector output stream)
module priority_code_decoder
   import priority_codec_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst,
   priority_code_decoder_if.slave         bus
);

   // ---------------------------------------------------------------
   // State and registers
   // ---------------------------------------------------------------
   state_t         r_state;
   state_t         w_state_nxt;

   logic           r_in_ready;
   logic           r_dec_valid;
   logic [N-1:0]   r_dec_onehot;

   logic [N-1:0]   r_acc;        // OR of strobes of the current frame so far
   logic           r_err_acc;    // sticky order violation within the current frame
   logic [CW-1:0]  r_prev_code;  // code of the previous beat of the frame
   logic           r_first;      // next accepted beat opens a new frame

   logic [N-1:0]   r_out_x;
   logic           r_out_err;
   logic           r_out_valid;

   // ---------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------
   logic [N-1:0]   w_strobe;
   logic           w_accept;
   logic           w_out_hs;
   logic           w_viol;

   onehot_decoder u_onehot_decoder (
      .i_code   (bus.in_code),
      .o_onehot (w_strobe)
   );

   // in_ready is only ever high in ACCUM, so the state term is belt-and-braces:
   // it guarantees no beat can slip in while the vector is being held.
   assign w_accept = bus.in_valid && r_in_ready && (r_state == ACCUM);
   assign w_out_hs = r_out_valid && bus.out_ready;

   // The first beat of a frame is always legal; later beats must strictly descend.
   // A duplicate code counts as a violation as well as an ascending one.
   assign w_viol   = !r_first && !(bus.in_code < r_prev_code);

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ACCUM: begin
            if (w_accept && bus.in_last) begin
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (w_out_hs) begin
               w_state_nxt = ACCUM;
            end
         end
         default: begin
            w_state_nxt = ACCUM;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Input ready and per-beat decode strobe
   // ---------------------------------------------------------------
   // in_ready is registered from the next state: it comes up one cycle after
   // reset release and one cycle after the output handshake, so a beat is never
   // accepted in the same cycle the held vector leaves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_ready   <= 1'b0;
         r_dec_valid  <= 1'b0;
         r_dec_onehot <= '0;
      end else begin
         r_in_ready  <= (w_state_nxt == ACCUM);
         r_dec_valid <= w_accept;
         if (w_accept) begin
            r_dec_onehot <= w_strobe;
         end
      end
   end

   // ---------------------------------------------------------------
   // Frame accumulation and output hold
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc       <= '0;
         r_err_acc   <= 1'b0;
         r_prev_code <= '0;
         r_first     <= 1'b1;
         r_out_x     <= '0;
         r_out_err   <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            if (bus.in_last) begin
               // Close the frame: the erroneous bit is still merged into the vector.
               r_out_x     <= r_acc | w_strobe;
               r_out_err   <= r_err_acc | w_viol;
               r_out_valid <= 1'b1;
               // Arm for the next frame.
               r_acc       <= '0;
               r_err_acc   <= 1'b0;
               r_prev_code <= '0;
               r_first     <= 1'b1;
            end else begin
               r_acc       <= r_acc | w_strobe;
               r_err_acc   <= r_err_acc | w_viol;
               r_prev_code <= bus.in_code;
               r_first     <= 1'b0;
            end
         end else if (w_out_hs) begin
            // out_x/out_err keep their last value; only the qualifier drops.
            r_out_valid <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------
   // Output drive
   // ---------------------------------------------------------------
   assign bus.in_ready   = r_in_ready;
   assign bus.dec_valid  = r_dec_valid;
   assign bus.dec_onehot = r_dec_onehot;
   assign bus.out_x      = r_out_x;
   assign bus.out_err    = r_out_err;
   assign bus.out_valid  = r_out_valid;

endmodule
